// File: rtl/mips_control_sequencer.sv
// -----------------------------------------------------------------------------
// mips_control_sequencer
//
// Multi-cycle control sequencer for a MIPS datapath. Accepts one instruction at
// a time over a valid/ready handshake, holds it on instrOut, and steps through
// IDLE -> DECODE -> (EXEC | MEMRD | MEMWR) -> WB -> DONE, driving the datapath
// control lines. Every output comes straight from a flop, so the write pulses
// (RegWrite, MemWrite) are glitch-free single-cycle pulses.
//
// Ports:
//   clk, reset          clock and asynchronous active-high reset
//   instrIn/instrValid  instruction offered by the fetch side
//   instrReady          high only while idle (accept on instrValid & instrReady)
//   instrOut            latched instruction toward the datapath
//   RegDst, ALUSrc, ALUCtrl, MemRead, MemtoReg, MemWrite, RegWrite
//                       datapath controls
//   busy                instruction in flight
//   done                one-cycle retire pulse
//   illegalInstr        one-cycle pulse with done for unsupported encodings
//   retiredCount        count of legal retirements, wraps
// -----------------------------------------------------------------------------
module mips_control_sequencer #(
    parameter int MEM_WAIT_CYCLES = 1,
    parameter int COUNT_WIDTH     = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:0]            instrIn,
    input  logic                   instrValid,
    output logic                   instrReady,
    output logic [31:0]            instrOut,
    output logic                   RegDst,
    output logic                   ALUSrc,
    output logic [3:0]             ALUCtrl,
    output logic                   MemRead,
    output logic                   MemtoReg,
    output logic                   MemWrite,
    output logic                   RegWrite,
    output logic                   busy,
    output logic                   done,
    output logic                   illegalInstr,
    output logic [COUNT_WIDTH-1:0] retiredCount
);

    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_EXEC, S_MEMRD, S_MEMWR, S_WB, S_DONE
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(MEM_WAIT_CYCLES - 1);

    state_t                 state_q, state_d;
    logic [31:0]            instr_q, instr_d;
    logic [3:0]             wait_q, wait_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;

    logic       ready_q, ready_d;
    logic       regdst_q, regdst_d;
    logic       alusrc_q, alusrc_d;
    logic [3:0] aluctrl_q, aluctrl_d;
    logic       memrd_q, memrd_d;
    logic       memtoreg_q, memtoreg_d;
    logic       memwr_q, memwr_d;
    logic       regwr_q, regwr_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       illegal_q, illegal_d;

    // Decode of the instruction that will be held during the next cycle.
    logic       dec_rtype, dec_addi, dec_lw, dec_sw, dec_legal;
    logic [3:0] dec_aluctrl;
    logic [4:0] dec_dest;

    always_comb begin
        dec_rtype   = 1'b0;
        dec_addi    = 1'b0;
        dec_lw      = 1'b0;
        dec_sw      = 1'b0;
        dec_aluctrl = 4'b0000;
        case (instr_d[31:26])
            6'h00: begin
                case (instr_d[5:0])
                    6'h20: begin dec_rtype = 1'b1; dec_aluctrl = 4'b0010; end
                    6'h22: begin dec_rtype = 1'b1; dec_aluctrl = 4'b0110; end
                    6'h24: begin dec_rtype = 1'b1; dec_aluctrl = 4'b0000; end
                    6'h25: begin dec_rtype = 1'b1; dec_aluctrl = 4'b0001; end
                    6'h27: begin dec_rtype = 1'b1; dec_aluctrl = 4'b1100; end
                    6'h2A: begin dec_rtype = 1'b1; dec_aluctrl = 4'b0111; end
                    default: ;
                endcase
            end
            6'h08: begin dec_addi = 1'b1; dec_aluctrl = 4'b0010; end
            6'h23: begin dec_lw   = 1'b1; dec_aluctrl = 4'b0010; end
            6'h2B: begin dec_sw   = 1'b1; dec_aluctrl = 4'b0010; end
            default: ;
        endcase
    end

    assign dec_legal = dec_rtype | dec_addi | dec_lw | dec_sw;
    assign dec_dest  = dec_rtype ? instr_d[15:11] : instr_d[20:16];

    // Next state, instruction latch, wait counter and retire counter.
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        wait_d  = wait_q;
        count_d = count_q;
        case (state_q)
            S_IDLE: begin
                if (instrValid) begin
                    instr_d = instrIn;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!dec_legal) begin
                    state_d = S_DONE;
                end else if (dec_lw) begin
                    state_d = S_MEMRD;
                    wait_d  = WAIT_INIT;
                end else if (dec_sw) begin
                    state_d = S_MEMWR;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC:  state_d = S_WB;
            S_MEMRD: begin
                if (wait_q == 4'd0) begin
                    state_d = S_WB;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            S_MEMWR: state_d = S_DONE;
            S_WB:    state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Count moves on the edge entering DONE so it is visible with done.
        if (state_d == S_DONE && dec_legal) begin
            count_d = count_q + 1'b1;
        end
    end

    // Registered outputs are computed from the state being entered, so each
    // control line is valid for the whole cycle of the state it belongs to.
    always_comb begin
        ready_d    = (state_d == S_IDLE);
        busy_d     = (state_d != S_IDLE);
        regdst_d   = 1'b0;
        alusrc_d   = 1'b0;
        aluctrl_d  = 4'b0000;
        memtoreg_d = 1'b0;
        if (state_d != S_IDLE && dec_legal) begin
            regdst_d   = dec_rtype;
            alusrc_d   = ~dec_rtype;
            aluctrl_d  = dec_aluctrl;
            memtoreg_d = dec_lw;
        end
        // MemRead stays up from MEMRD until the instruction leaves DONE.
        memrd_d   = dec_lw && (state_d inside {S_MEMRD, S_WB, S_DONE});
        memwr_d   = (state_d == S_MEMWR);
        // Writes to $0 are suppressed; the instruction still retires.
        regwr_d   = (state_d == S_WB) && (dec_dest != 5'd0);
        done_d    = (state_d == S_DONE);
        illegal_d = (state_d == S_DONE) && !dec_legal;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            instr_q    <= 32'd0;
            wait_q     <= 4'd0;
            count_q    <= '0;
            ready_q    <= 1'b1;
            regdst_q   <= 1'b0;
            alusrc_q   <= 1'b0;
            aluctrl_q  <= 4'b0000;
            memrd_q    <= 1'b0;
            memtoreg_q <= 1'b0;
            memwr_q    <= 1'b0;
            regwr_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            wait_q     <= wait_d;
            count_q    <= count_d;
            ready_q    <= ready_d;
            regdst_q   <= regdst_d;
            alusrc_q   <= alusrc_d;
            aluctrl_q  <= aluctrl_d;
            memrd_q    <= memrd_d;
            memtoreg_q <= memtoreg_d;
            memwr_q    <= memwr_d;
            regwr_q    <= regwr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            illegal_q  <= illegal_d;
        end
    end

    assign instrReady   = ready_q;
    assign instrOut     = instr_q;
    assign RegDst       = regdst_q;
    assign ALUSrc       = alusrc_q;
    assign ALUCtrl      = aluctrl_q;
    assign MemRead      = memrd_q;
    assign MemtoReg     = memtoreg_q;
    assign MemWrite     = memwr_q;
    assign RegWrite     = regwr_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign illegalInstr = illegal_q;
    assign retiredCount = count_q;

endmodule

// File: tb/tb_mips_control_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mips_control_sequencer
//
// Directed bench. A latency-table model (per instruction class: cycle of
// RegWrite, MemWrite, MemRead window, done) predicts every output on every
// cycle; hand-computed cycle numbers and counts pin the model.
// -----------------------------------------------------------------------------
module tb_mips_control_sequencer;

    localparam int MW = 3;
    localparam int CW = 4;

    localparam int C_ILL  = 0;
    localparam int C_R    = 1;
    localparam int C_ADDI = 2;
    localparam int C_LW   = 3;
    localparam int C_SW   = 4;

    logic          clk;
    logic          reset;
    logic [31:0]   instrIn;
    logic          instrValid;
    logic          instrReady;
    logic [31:0]   instrOut;
    logic          RegDst, ALUSrc, MemRead, MemtoReg, MemWrite, RegWrite;
    logic [3:0]    ALUCtrl;
    logic          busy, done, illegalInstr;
    logic [CW-1:0] retiredCount;

    mips_control_sequencer #(.MEM_WAIT_CYCLES(MW), .COUNT_WIDTH(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .instrIn      (instrIn),
        .instrValid   (instrValid),
        .instrReady   (instrReady),
        .instrOut     (instrOut),
        .RegDst       (RegDst),
        .ALUSrc       (ALUSrc),
        .ALUCtrl      (ALUCtrl),
        .MemRead      (MemRead),
        .MemtoReg     (MemtoReg),
        .MemWrite     (MemWrite),
        .RegWrite     (RegWrite),
        .busy         (busy),
        .done         (done),
        .illegalInstr (illegalInstr),
        .retiredCount (retiredCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: in-flight flag, cycle index since accept (1 = DECODE cycle).
    logic          m_busy;
    logic [31:0]   m_instr;
    int            m_t;
    logic [CW-1:0] m_cnt;

    logic [31:0] stream [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int cls_of(input logic [31:0] ins);
        logic [5:0] op;
        logic [5:0] fn;
        op = ins[31:26];
        fn = ins[5:0];
        if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 ||
                            fn == 6'h25 || fn == 6'h27 || fn == 6'h2A)) return C_R;
        if (op == 6'h08) return C_ADDI;
        if (op == 6'h23) return C_LW;
        if (op == 6'h2B) return C_SW;
        return C_ILL;
    endfunction

    function automatic int len_of(input int c);
        case (c)
            C_R, C_ADDI: return 4;
            C_LW:        return 3 + MW;
            C_SW:        return 3;
            default:     return 2;
        endcase
    endfunction

    function automatic logic [3:0] alu_of(input logic [31:0] ins);
        int c;
        c = cls_of(ins);
        if (c == C_ILL) return 4'd0;
        if (c != C_R) return 4'd2;
        case (ins[5:0])
            6'h20: return 4'd2;
            6'h22: return 4'd6;
            6'h24: return 4'd0;
            6'h25: return 4'd1;
            6'h27: return 4'd12;
            default: return 4'd7;
        endcase
    endfunction

    task automatic model_reset();
        m_busy  = 1'b0;
        m_instr = 32'd0;
        m_t     = 0;
        m_cnt   = '0;
    endtask

    task automatic model_edge();
        if (reset) return;
        if (!m_busy) begin
            if (instrValid) begin
                m_busy  = 1'b1;
                m_instr = instrIn;
                m_t     = 1;
            end
        end else begin
            m_t++;
            if (m_t > len_of(cls_of(m_instr))) m_busy = 1'b0;
        end
        if (m_busy && m_t == len_of(cls_of(m_instr)) && cls_of(m_instr) != C_ILL)
            m_cnt = m_cnt + 1'b1;
    endtask

    task automatic compare_all();
        int   c, len;
        logic [4:0] dst;
        logic e_done;
        c   = cls_of(m_instr);
        len = len_of(c);
        dst = (c == C_R) ? m_instr[15:11] : m_instr[20:16];
        e_done = m_busy && m_t == len;
        chk("instrReady", instrReady, !m_busy);
        chk("busy",       busy,       m_busy);
        chk("instrOut",   instrOut,   m_instr);
        chk("RegDst",     RegDst,     m_busy && c == C_R);
        chk("ALUSrc",     ALUSrc,     m_busy && (c == C_ADDI || c == C_LW || c == C_SW));
        chk("ALUCtrl",    ALUCtrl,    m_busy ? alu_of(m_instr) : 4'd0);
        chk("MemtoReg",   MemtoReg,   m_busy && c == C_LW);
        chk("MemRead",    MemRead,    m_busy && c == C_LW && m_t >= 2);
        chk("MemWrite",   MemWrite,   m_busy && c == C_SW && m_t == 2);
        chk("RegWrite",   RegWrite,   m_busy && (c == C_R || c == C_ADDI || c == C_LW) &&
                                      m_t == len - 1 && dst != 5'd0);
        chk("done",       done,       e_done);
        chk("illegal",    illegalInstr, e_done && c == C_ILL);
        chk("retiredCount", retiredCount, m_cnt);
        if (e_done)
            $display("retire instr=%08h illegal=%0d count=%0d t=%0t",
                     m_instr, (c == C_ILL), retiredCount, $time);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    // Offer one instruction from idle; record the cycle indices at which the
    // DUT pulsed RegWrite/MemWrite/done and compare with hand-computed values.
    task automatic run_one(input string name, input logic [31:0] ins, input int e_done,
                           input int e_rw, input int e_mw, input int e_mr);
        int c, rw_c, mw_c, done_c, mr_n;
        rw_c = 0; mw_c = 0; done_c = 0; mr_n = 0;
        instrIn    = ins;
        instrValid = 1'b1;
        step();
        instrValid = 1'b0;
        c = 1;
        forever begin
            if (RegWrite) rw_c = c;
            if (MemWrite) mw_c = c;
            if (MemRead)  mr_n++;
            if (done)     done_c = c;
            if (done_c != 0 || c >= 40) break;
            step();
            c++;
        end
        step();
        chk({name, "_done_cycle"}, done_c, e_done);
        chk({name, "_regwrite_cycle"}, rw_c, e_rw);
        chk({name, "_memwrite_cycle"}, mw_c, e_mw);
        chk({name, "_memread_cycles"}, mr_n, e_mr);
        chk({name, "_ready_after"}, instrReady, 1);
    endtask

    initial begin
        int idx;
        stream[0]  = 32'h00221820; stream[1]  = 32'h00221822; stream[2]  = 32'h00221824;
        stream[3]  = 32'h00221825; stream[4]  = 32'h00221827; stream[5]  = 32'h0022182A;
        stream[6]  = 32'h20010005; stream[7]  = 32'h8C050004; stream[8]  = 32'hAC050008;
        stream[9]  = 32'h00220020; stream[10] = 32'h01095020; stream[11] = 32'h8C0A0010;
        stream[12] = 32'hAC0A0014; stream[13] = 32'h2129FFFF; stream[14] = 32'h01095022;
        stream[15] = 32'h0109502A; stream[16] = 32'h01095027;

        reset      = 1'b0;
        instrIn    = 32'd0;
        instrValid = 1'b0;
        model_reset();
        #1 reset = 1'b1;
        #2;
        chk("rst_instrReady", instrReady, 1);
        chk("rst_busy",       busy, 0);
        chk("rst_instrOut",   instrOut, 0);
        chk("rst_count",      retiredCount, 0);
        chk("rst_controls",   {RegDst, ALUSrc, ALUCtrl, MemRead, MemtoReg, MemWrite,
                               RegWrite, done, illegalInstr}, 0);
        @(negedge clk);
        reset = 1'b0;
        step();

        run_one("add", 32'h00221820, 4, 3, 0, 0);
        chk("add_count", retiredCount, 1);
        run_one("lw", 32'h8C050004, 6, 5, 0, 5);
        chk("lw_count", retiredCount, 2);
        run_one("sw", 32'hAC050008, 3, 0, 2, 0);
        chk("sw_count", retiredCount, 3);
        run_one("addi0", 32'h20000005, 4, 0, 0, 0);
        chk("addi0_count", retiredCount, 4);
        run_one("badop", 32'hFC000000, 2, 0, 0, 0);
        run_one("badfn", 32'h00221821, 2, 0, 0, 0);
        chk("illegal_count", retiredCount, 4);

        // Reset during the WB cycle of an add.
        instrIn    = 32'h00221820;
        instrValid = 1'b1;
        step();
        instrValid = 1'b0;
        step();
        step();
        chk("wb_regwrite_pre", RegWrite, 1);
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk("wbrst_regwrite", RegWrite, 0);
        chk("wbrst_busy",     busy, 0);
        chk("wbrst_done",     done, 0);
        chk("wbrst_count",    retiredCount, 0);
        chk("wbrst_instrOut", instrOut, 0);
        chk("wbrst_ready",    instrReady, 1);
        @(negedge clk);
        reset = 1'b0;
        step();
        chk("wbrst_ready_after", instrReady, 1);

        // 17 legal instructions, instrValid held high throughout.
        idx        = 0;
        instrIn    = stream[0];
        instrValid = 1'b1;
        for (int cyc = 0; cyc < 400 && idx < 17; cyc++) begin
            logic acc;
            acc = instrReady;
            step();
            if (acc) begin
                idx++;
                if (idx < 17) instrIn = stream[idx];
                else instrValid = 1'b0;
            end
        end
        for (int k = 0; k < 20 && m_busy; k++) step();
        step();
        chk("stream_accepts", idx, 17);
        chk("stream_wrap_count", retiredCount, 1);
        chk("stream_idle", instrReady, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_control_sequencer.md
Name: mips_control_sequencer

Overview:
Multi-cycle control sequencer for the single-cycle MIPS datapath. It accepts one 32-bit instruction at a time over a valid/ready handshake, holds it stable toward the datapath, and decodes opcode/funct into RegDst, ALUSrc, ALUCtrl, MemRead, MemtoReg, MemWrite and RegWrite. Control steps are ordered so that register-file and memory writes occur as single clean registered pulses after operands have settled. A retired-instruction counter and an illegal-instruction flag are provided for the testbench.

Parameters:
MEM_WAIT_CYCLES, 1, cycles MemRead is held in MEMRD before writeback (range 1..15).
COUNT_WIDTH, 16, width of retiredCount.

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
instrIn  input  32  instruction offered by the fetch side
instrValid  input  1  instrIn valid
instrReady  output  1  sequencer can accept (high only in IDLE)
instrOut  output  32  latched instruction driven to the datapath
RegDst  output  1  1 = write to rd, 0 = write to rt
ALUSrc  output  1  1 = sign-extended immediate to ALU op2
ALUCtrl  output  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR
MemRead  output  1  memory read enable
MemtoReg  output  1  1 = memory data to register write port
MemWrite  output  1  memory write pulse
RegWrite  output  1  register-file write pulse (the register file writes on its rising edge)
busy  output  1  instruction in flight (state != IDLE)
done  output  1  one-cycle pulse when an instruction retires
illegalInstr  output  1  one-cycle pulse, coincident with done, for unsupported encodings
retiredCount  output  COUNT_WIDTH  legal instructions retired; wraps modulo 2^COUNT_WIDTH

Behaviour:
- All outputs are registered, so there are no glitches on RegWrite or MemWrite.
- On reset, the FSM goes to IDLE. instrOut=0, retiredCount=0, and all other outputs are 0 except instrReady=1.
- Reset asserted mid-instruction aborts it immediately. Any in-progress RegWrite/MemWrite pulse drops with reset. There is no done pulse and no count increment.
- Supported encodings:
  - R-type (opcode 0x00): funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x27 nor, 0x2A slt.
  - opcode 0x08 addi, 0x23 lw, 0x2B sw.
  - Everything else is illegal.
- States: IDLE, DECODE, EXEC, MEMRD, MEMWR, WB, DONE.
- IDLE:
  - instrReady=1 and all control outputs are 0.
  - If instrValid=1 at a rising edge, latch instrIn into instrOut and go to DECODE.
  - instrValid while not in IDLE is ignored; the producer must hold it.
- DECODE (1 cycle):
  - Set RegDst/ALUSrc/ALUCtrl/MemtoReg; they stay constant until DONE exits.
  - R-type: RegDst=1, ALUSrc=0, ALUCtrl per funct.
  - addi/lw/sw: RegDst=0, ALUSrc=1, ALUCtrl=0010.
  - lw: MemtoReg=1.
  - Next state: illegal -> DONE; R-type/addi -> EXEC; lw -> MEMRD; sw -> MEMWR.
- EXEC (1 cycle): ALU settles; go to WB.
- MEMRD:
  - MemRead=1 for MEM_WAIT_CYCLES cycles, tracked by an internal wait counter.
  - Go to WB; MemRead stays 1 through WB.
- MEMWR: MemWrite=1 for exactly this one cycle; go to DONE. RegWrite is never asserted for sw.
- WB:
  - RegWrite=1 for exactly one cycle; go to DONE.
  - If the destination register (rd when RegDst=1, else rt) is 0, RegWrite stays 0 and the instruction still retires normally.
- DONE (1 cycle):
  - done=1.
  - Legal instruction: retiredCount increments. Illegal: illegalInstr=1 and no increment.
  - Control outputs clear on exit; go to IDLE.
- Latency, measured from the accept edge (cycle 0):
  - R-type/addi: RegWrite in cycle 3, done in cycle 4, instrReady back in cycle 5.
  - lw: RegWrite in cycle 2+MEM_WAIT_CYCLES, done in cycle 3+MEM_WAIT_CYCLES.
  - sw: MemWrite in cycle 2, done in cycle 3.
  - Illegal: done and illegalInstr in cycle 2.
- Back-to-back: an instruction held valid during DONE is accepted on the first IDLE edge, so there is at least one idle cycle between instructions.
- retiredCount at all ones plus one retire wraps to 0.

Test Plan:
- Reset, then instrIn=0x00221820 (add $3,$1,$2) valid -> RegDst=1, ALUSrc=0, ALUCtrl=0010 from cycle 1. RegWrite=1 only in cycle 3. done in cycle 4. retiredCount=1.
- instrIn=0x8C050004 (lw $5,4($0)), MEM_WAIT_CYCLES=3 -> MemRead=1 in cycles 2-6, MemtoReg=1, RegDst=0, ALUSrc=1. RegWrite in cycle 5. done in cycle 6. MemWrite never asserted.
- instrIn=0xAC050008 (sw $5,8($0)) -> MemWrite=1 only in cycle 2, RegWrite stays 0, done in cycle 3. Then 0x20000005 (addi $0,$0,5) -> RegWrite stays 0, done pulses, retiredCount increments.
- instrIn=0xFC000000 (opcode 0x3F) and 0x00221821 (bad funct) -> done and illegalInstr in cycle 2. No RegWrite/MemWrite. retiredCount unchanged.
- Assert reset during WB of an add -> RegWrite, busy and all other outputs drop asynchronously. No done. retiredCount=0. instrReady=1 after reset release.
- COUNT_WIDTH=4: retire 17 legal instructions with instrValid held high continuously -> retiredCount=1 after wrap. Each instruction is accepted only when instrReady=1; no instruction is lost or duplicated.
